// File: rtl/holy_core_pkg.sv
// ============================================================================
// Module : holy_core_pkg
// Brief  : Shared types and constants for the holy_lite_arbiter AXI-Lite MMIO sharing block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package holy_core_pkg;

    localparam int ARB_NUM_REQ = 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } arb_state_t;

    // The one-hot ack vector for the requester with the given index.
    function automatic logic [ARB_NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : holy_core_pkg

`default_nettype wire

// File: rtl/holy_rr_picker.sv
// ============================================================================
// Module : holy_rr_picker
// Brief  : 2-way request picker. The default build resolves a tie with a round-robin pointer.
//          When HOLY_LITE_ARB_FIXED_PRIO_EN is defined, requester 1 always wins a tie.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module holy_rr_picker
    import holy_core_pkg::*;
(
`ifndef HOLY_LITE_ARB_FIXED_PRIO_EN
    input  logic                   ptr,
`endif
    input  logic [ARB_NUM_REQ-1:0] req,
    output logic [ARB_NUM_REQ-1:0] grant
);

    always_comb begin
        grant = req;
        if (&req) begin
`ifdef HOLY_LITE_ARB_FIXED_PRIO_EN
            grant = 2'b10;
`else
            grant = ptr ? 2'b10 : 2'b01;
`endif
        end
    end

endmodule : holy_rr_picker

`default_nettype wire

// File: rtl/holy_lite_arbiter.sv
// ============================================================================
// Module : holy_lite_arbiter
// Brief  : Shares one AXI-Lite master between the core's non-cacheable path (req 0) and the debug
//          system-bus (req 1). It allows one outstanding transaction and uses a registered req/ack handshake.
//          Define HOLY_LITE_ARB_FIXED_PRIO_EN to make requester 1 win every tie.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module holy_lite_arbiter
    import holy_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_we,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    input  logic [2*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [1:0]                req_ack,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,

    output logic [ADDR_WIDTH-1:0]     m_axi_lite_awaddr,
    output logic                      m_axi_lite_awvalid,
    input  logic                      m_axi_lite_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_lite_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_lite_wstrb,
    output logic                      m_axi_lite_wvalid,
    input  logic                      m_axi_lite_wready,

    input  logic [1:0]                m_axi_lite_bresp,
    input  logic                      m_axi_lite_bvalid,
    output logic                      m_axi_lite_bready,

    output logic [ADDR_WIDTH-1:0]     m_axi_lite_araddr,
    output logic                      m_axi_lite_arvalid,
    input  logic                      m_axi_lite_arready,

    input  logic [DATA_WIDTH-1:0]     m_axi_lite_rdata,
    input  logic [1:0]                m_axi_lite_rresp,
    input  logic                      m_axi_lite_rvalid,
    output logic                      m_axi_lite_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_t r_state;
    logic       r_grant;
`ifndef HOLY_LITE_ARB_FIXED_PRIO_EN
    logic       r_rr_ptr;
`endif

    logic [1:0]            w_eligible;
    logic [1:0]            w_pick;
    logic                  w_win_idx;
    logic                  w_win_we;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;
    logic [STRB_WIDTH-1:0] w_win_wstrb;
    logic                  w_aw_done;
    logic                  w_w_done;

    // A requester whose ack is in flight this cycle still holds req_valid; it must not be regranted.
    assign w_eligible = req_valid & ~req_ack;

    holy_rr_picker u_picker (
`ifndef HOLY_LITE_ARB_FIXED_PRIO_EN
        .ptr   (r_rr_ptr),
`endif
        .req   (w_eligible),
        .grant (w_pick)
    );

    assign w_win_idx   = w_pick[1];
    assign w_win_we    = w_win_idx ? req_we[1] : req_we[0];
    assign w_win_addr  = w_win_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0];
    assign w_win_wdata = w_win_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : req_wdata[DATA_WIDTH-1:0];
    assign w_win_wstrb = w_win_idx ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                                   : req_wstrb[STRB_WIDTH-1:0];

    // A channel counts as finished if it already handshook or if it handshakes on this edge.
    assign w_aw_done = ~m_axi_lite_awvalid | m_axi_lite_awready;
    assign w_w_done  = ~m_axi_lite_wvalid  | m_axi_lite_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= IDLE;
            r_grant            <= 1'b0;
`ifndef HOLY_LITE_ARB_FIXED_PRIO_EN
            r_rr_ptr           <= 1'b0;
`endif
            req_ack            <= '0;
            rsp_rdata          <= '0;
            rsp_err            <= 1'b0;
            m_axi_lite_awaddr  <= '0;
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_wdata   <= '0;
            m_axi_lite_wstrb   <= '0;
            m_axi_lite_wvalid  <= 1'b0;
            m_axi_lite_bready  <= 1'b0;
            m_axi_lite_araddr  <= '0;
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_rready  <= 1'b0;
        end else begin
            req_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_pick) begin
                        r_grant  <= w_win_idx;
`ifndef HOLY_LITE_ARB_FIXED_PRIO_EN
                        r_rr_ptr <= ~w_win_idx;
`endif
                        if (w_win_we) begin
                            m_axi_lite_awaddr  <= w_win_addr;
                            m_axi_lite_wdata   <= w_win_wdata;
                            m_axi_lite_wstrb   <= w_win_wstrb;
                            m_axi_lite_awvalid <= 1'b1;
                            m_axi_lite_wvalid  <= 1'b1;
                            r_state            <= WRITE;
                        end else begin
                            m_axi_lite_araddr  <= w_win_addr;
                            m_axi_lite_arvalid <= 1'b1;
                            r_state            <= RADDR;
                        end
                    end
                end

                WRITE: begin
                    if (m_axi_lite_awvalid && m_axi_lite_awready) begin
                        m_axi_lite_awvalid <= 1'b0;
                    end
                    if (m_axi_lite_wvalid && m_axi_lite_wready) begin
                        m_axi_lite_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        m_axi_lite_bready <= 1'b1;
                        r_state           <= WRESP;
                    end
                end

                WRESP: begin
                    if (m_axi_lite_bvalid) begin
                        req_ack           <= idx_to_onehot(r_grant);
                        rsp_err           <= (m_axi_lite_bresp != AXI_RESP_OKAY);
                        m_axi_lite_bready <= 1'b0;
                        r_state           <= IDLE;
                    end
                end

                RADDR: begin
                    if (m_axi_lite_arready) begin
                        m_axi_lite_arvalid <= 1'b0;
                        m_axi_lite_rready  <= 1'b1;
                        r_state            <= RDATA;
                    end
                end

                RDATA: begin
                    if (m_axi_lite_rvalid) begin
                        req_ack           <= idx_to_onehot(r_grant);
                        rsp_rdata         <= m_axi_lite_rdata;
                        rsp_err           <= (m_axi_lite_rresp != AXI_RESP_OKAY);
                        m_axi_lite_rready <= 1'b0;
                        r_state           <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : holy_lite_arbiter

`default_nettype wire
